// File: rtl/rr_onehot_req_arbiter.sv
// Round-robin arbiter feeding the one-hot request encoder.
// Raw, possibly overlapping request lines become a registered grant vector
// that is always one-hot or all-zero. A grant is held until the owner
// releases it, drops its request, or reaches the MAX_HOLD cycle limit.
// There is always at least one all-zero cycle between two grants.
//
// Grant handshake: gnt_valid is high exactly when gnt_onehot has a bit set,
// and gnt_idx names that bit. While gnt_valid is high the grant stays stable
// until the owner asserts done, drops req[gnt_idx], or the hold limit
// expires. The grant clears on the edge where any of these is seen.
// done is ignored while no grant is outstanding.
module rr_onehot_req_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt_onehot,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 timeout
);

    localparam int IW = $clog2(N);
    // hold_cnt only needs to reach MAX_HOLD-1; keep at least one bit
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // state is kept as a named enum so checkers can bind to it directly
    state_t          state;
    logic [IW-1:0]   ptr;
    logic [HW-1:0]   hold_cnt;

    logic            scan_hit;
    logic [IW-1:0]   scan_idx;
    logic [IW-1:0]   pidx;
    int              pos;
    logic            release_now;
    logic            limit_hit;
    logic [IW-1:0]   next_ptr;

    // Find the first requesting line starting at ptr and wrapping around
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        pos      = 0;
        pidx     = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            pidx = IW'(pos);
            if (!scan_hit && req[pidx]) begin
                scan_hit = 1'b1;
                scan_idx = pidx;
            end
        end
    end

    // Release decision for the current owner and the pointer that follows it
    always_comb begin
        limit_hit   = (hold_cnt == HOLD_LAST);
        release_now = done || !req[gnt_idx] || limit_hit;
        next_ptr    = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
    end

    // Grant FSM with registered outputs; reset clears any grant at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_onehot <= '0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            timeout    <= 1'b0;
            ptr        <= '0;
            hold_cnt   <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_hit) begin
                        state      <= GRANT;
                        gnt_onehot <= N'(1) << scan_idx;
                        gnt_idx    <= scan_idx;
                        gnt_valid  <= 1'b1;
                        hold_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state      <= IDLE;
                        gnt_onehot <= '0;
                        gnt_valid  <= 1'b0;
                        gnt_idx    <= '0;
                        hold_cnt   <= '0;
                        ptr        <= next_ptr;
                        // pulse only when the hold limit alone forced the release
                        timeout    <= !done && req[gnt_idx];
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_onehot_req_arbiter.sv
// Bench for rr_onehot_req_arbiter: table of directed vectors, hand-written
// async-reset sequence, then randomized traffic against a reference model.
module tb_rr_onehot_req_arbiter;

    localparam int N        = 3;
    localparam int MAX_HOLD = 4;
    localparam int IW       = $clog2(N);

    // ---------------- clock / reset ----------------
    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req   = '0;
    logic          done  = 1'b0;
    logic [N-1:0]  gnt_onehot;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic          timeout;

    always #5 clk = ~clk;

    rr_onehot_req_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .gnt_onehot (gnt_onehot),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .timeout    (timeout)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_invariants();
        check("inv_onehot0", 32'($onehot0(gnt_onehot)), 32'd1);
        check("inv_valid",   32'(gnt_valid), 32'(|gnt_onehot));
        check("inv_idx",     32'(gnt_onehot), 32'(N'(gnt_valid) << gnt_idx));
    endtask

    // ---------------- reference model ----------------
    // owner is -1 when nothing is granted; held counts visible grant cycles
    int m_owner   = -1;
    int m_ptr     = 0;
    int m_held    = 0;
    bit m_timeout = 1'b0;

    function automatic void model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_held    = 0;
        m_timeout = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic d);
        int c;
        if (m_owner < 0) begin
            m_timeout = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c;
                    m_held  = 1;
                end
            end
        end else if (d || !r[m_owner] || m_held == MAX_HOLD) begin
            m_timeout = !d && r[m_owner];
            m_ptr     = (m_owner + 1) % N;
            m_owner   = -1;
        end else begin
            m_held++;
            m_timeout = 1'b0;
        end
    endfunction

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic int idx_of(input logic [N-1:0] g);
        int r;
        r = 0;
        for (int k = 0; k < N; k++) begin
            if (g[k]) r = k;
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input logic [N-1:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_invariants();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] exp_gnt;
        logic         exp_to;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_vec(input logic [N-1:0] r, input logic d,
                                    input logic [N-1:0] g, input logic t);
        vec_t v;
        v.req = r; v.done = d; v.exp_gnt = g; v.exp_to = t;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [N-1:0] r_rand;
        logic         d_rand;

        // idle after reset
        for (int i = 0; i < 5; i++) add_vec(3'b000, 1'b0, 3'b000, 1'b0);
        // all requesting, done one cycle after each grant: rotate with gaps
        add_vec(3'b111, 1'b0, 3'b001, 1'b0);
        add_vec(3'b111, 1'b1, 3'b000, 1'b0);
        add_vec(3'b111, 1'b0, 3'b010, 1'b0);
        add_vec(3'b111, 1'b1, 3'b000, 1'b0);
        add_vec(3'b111, 1'b0, 3'b100, 1'b0);
        add_vec(3'b111, 1'b1, 3'b000, 1'b0);
        add_vec(3'b111, 1'b0, 3'b001, 1'b0);
        add_vec(3'b111, 1'b1, 3'b000, 1'b0);
        // single requester held: 4 grant cycles, timeout gap, re-grant
        for (int i = 0; i < 4; i++) add_vec(3'b010, 1'b0, 3'b010, 1'b0);
        add_vec(3'b010, 1'b0, 3'b000, 1'b1);
        add_vec(3'b010, 1'b0, 3'b010, 1'b0);
        add_vec(3'b010, 1'b1, 3'b000, 1'b0);
        // owner drops its request: release without timeout, next from ptr=1
        add_vec(3'b001, 1'b0, 3'b001, 1'b0);
        add_vec(3'b110, 1'b0, 3'b000, 1'b0);
        add_vec(3'b110, 1'b0, 3'b010, 1'b0);
        add_vec(3'b110, 1'b1, 3'b000, 1'b0);
        // done coincides with the last allowed hold cycle: no timeout, ptr moves
        add_vec(3'b100, 1'b0, 3'b100, 1'b0);
        for (int i = 0; i < 3; i++) add_vec(3'b100, 1'b0, 3'b100, 1'b0);
        add_vec(3'b100, 1'b1, 3'b000, 1'b0);
        add_vec(3'b111, 1'b0, 3'b001, 1'b0);
        add_vec(3'b111, 1'b1, 3'b000, 1'b0);

        do_reset();
        #1;
        check("reset_gnt",     32'(gnt_onehot), 32'd0);
        check("reset_valid",   32'(gnt_valid),  32'd0);
        check("reset_idx",     32'(gnt_idx),    32'd0);
        check("reset_timeout", 32'(timeout),    32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].req, tbl[i].done);
            check($sformatf("tbl%0d_gnt", i),     32'(gnt_onehot), 32'(tbl[i].exp_gnt));
            check($sformatf("tbl%0d_valid", i),   32'(gnt_valid),  32'(|tbl[i].exp_gnt));
            check($sformatf("tbl%0d_idx", i),     32'(gnt_idx),    32'(idx_of(tbl[i].exp_gnt)));
            check($sformatf("tbl%0d_timeout", i), 32'(timeout),    32'(tbl[i].exp_to));
        end

        // async reset between edges while a grant is held (ptr is 1 here)
        tick(3'b010, 1'b0);
        check("pre_rst_gnt", 32'(gnt_onehot), 32'b010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt",   32'(gnt_onehot), 32'd0);
        check("async_rst_valid", 32'(gnt_valid),  32'd0);
        check("async_rst_idx",   32'(gnt_idx),    32'd0);
        model_reset();
        req = 3'b100;
        @(negedge clk);
        rst_n = 1'b1;
        tick(3'b100, 1'b0);
        check("post_rst_gnt", 32'(gnt_onehot), 32'b100);
        check("post_rst_idx", 32'(gnt_idx),    32'd2);
        tick(3'b100, 1'b1);
        check("post_rst_rel", 32'(gnt_onehot), 32'd0);

        // randomized traffic against the model
        do_reset();
        r_rand = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r_rand = N'($urandom_range(0, (1 << N) - 1));
            d_rand = ($urandom_range(0, 5) == 0);
            tick(r_rand, d_rand);
            check("rnd_gnt",     32'(gnt_onehot), 32'(model_gnt()));
            check("rnd_valid",   32'(gnt_valid),  32'(m_owner >= 0));
            check("rnd_idx",     32'(gnt_idx),    32'((m_owner >= 0) ? m_owner : 0));
            check("rnd_timeout", 32'(timeout),    32'(m_timeout));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
